// File: rtl/fp32_maxmin_reduce_pkg.sv
// Shared definitions for the fp32 max/min reduction controller: FP32 field widths,
// the canonical NaN result, comparator op codes and the controller state encoding.
package fp32_maxmin_reduce_pkg;

  localparam int FP_W   = 32;
  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;

  localparam logic [FP_W-1:0] QNAN = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    CMP_GTE = 3'd0,
    CMP_GT  = 3'd1,
    CMP_EQ  = 3'd2,
    CMP_LT  = 3'd3,
    CMP_LTE = 3'd4
  } cmp_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/fp32_maxmin_reduce_if.sv
// Bundle of the element stream, comparator request/response and result stream.
// slave = reduction controller side, master = surrounding datapath / environment.
interface fp32_maxmin_reduce_if
  import fp32_maxmin_reduce_pkg::*;
#(
  parameter int IDX_W = 5
);

  logic              i_valid;
  logic [FP_W-1:0]   i_data;
  logic              i_last;
  logic              i_mode;
  logic              o_ready;

  logic              o_cmp_valid;
  logic [2:0]        o_cmp_op;
  logic [FP_W-1:0]   o_cmp_a;
  logic [FP_W-1:0]   o_cmp_b;
  logic              i_cmp_valid;
  logic              i_cmp_result;
  logic              i_cmp_nan;

  logic              o_valid;
  logic [FP_W-1:0]   o_value;
  logic [IDX_W-1:0]  o_index;
  logic              o_nan_err;
  logic              o_trunc;
  logic              i_out_ready;

  modport slave (
    input  i_valid, i_data, i_last, i_mode,
    output o_ready,
    output o_cmp_valid, o_cmp_op, o_cmp_a, o_cmp_b,
    input  i_cmp_valid, i_cmp_result, i_cmp_nan,
    output o_valid, o_value, o_index, o_nan_err, o_trunc,
    input  i_out_ready
  );

  modport master (
    output i_valid, i_data, i_last, i_mode,
    input  o_ready,
    input  o_cmp_valid, o_cmp_op, o_cmp_a, o_cmp_b,
    output i_cmp_valid, i_cmp_result, i_cmp_nan,
    input  o_valid, o_value, o_index, o_nan_err, o_trunc,
    output i_out_ready
  );

endinterface

// File: rtl/fp32_is_nan.sv
// Combinational NaN detect on the magnitude bits of an FP32 word (sign is irrelevant).
module fp32_is_nan
  import fp32_maxmin_reduce_pkg::*;
(
  input  logic [FP_W-2:0] i_abs,
  output logic            o_nan
);

  assign o_nan = (&i_abs[FP_W-2 -: EXP_W]) && (|i_abs[MANT_W-1:0]);

endmodule

// File: rtl/fp32_maxmin_reduce.sv
// Streaming max/min reduction controller; drives an external 1-cycle fp32 comparator
// with each new element against the running extreme and reports value, index and flags.
//
// state     | meaning
// ST_IDLE   | waiting for first element of a vector
// ST_ACCEPT | waiting for next element; issues comparator request on acceptance
// ST_WAIT   | waiting for comparator result for the pending element
// ST_DONE   | result presented until downstream accepts
module fp32_maxmin_reduce
  import fp32_maxmin_reduce_pkg::*;
#(
  parameter int IDX_W = 5
)(
  input  logic                  clk,
  input  logic                  rst,
  fp32_maxmin_reduce_if.slave   bus
);

  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{IDX_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {1'b1, {IDX_W{1'b0}}};

  state_e            state_q,     state_d;
  logic [FP_W-1:0]   running_q,   running_d;
  logic [IDX_W-1:0]  index_q,     index_d;
  logic [CNT_W-1:0]  count_q,     count_d;
  logic              mode_q,      mode_d;
  logic              nan_q,       nan_d;
  logic              trunc_q,     trunc_d;
  logic [FP_W-1:0]   elem_q,      elem_d;
  logic              elem_last_q, elem_last_d;
  logic [FP_W-1:0]   cmp_a_q,     cmp_a_d;
  logic [FP_W-1:0]   cmp_b_q,     cmp_b_d;
  cmp_op_e           cmp_op_q,    cmp_op_d;
  logic              cmp_req;
  logic              first_nan;

  fp32_is_nan u_is_nan (
    .i_abs (bus.i_data[FP_W-2:0]),
    .o_nan (first_nan)
  );

  always_comb begin
    state_d     = state_q;
    running_d   = running_q;
    index_d     = index_q;
    count_d     = count_q;
    mode_d      = mode_q;
    nan_d       = nan_q;
    trunc_d     = trunc_q;
    elem_d      = elem_q;
    elem_last_d = elem_last_q;
    cmp_a_d     = cmp_a_q;
    cmp_b_d     = cmp_b_q;
    cmp_op_d    = cmp_op_q;
    cmp_req     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_valid) begin
          running_d = bus.i_data;
          index_d   = '0;
          count_d   = CNT_ONE;
          mode_d    = bus.i_mode;
          nan_d     = first_nan;
          trunc_d   = 1'b0;
          state_d   = bus.i_last ? ST_DONE : ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        // Request is combinational so the registered comparator answers in WAIT.
        if (bus.i_valid) begin
          elem_d      = bus.i_data;
          elem_last_d = bus.i_last;
          cmp_req     = 1'b1;
          cmp_a_d     = bus.i_data;
          cmp_b_d     = running_q;
          cmp_op_d    = mode_q ? CMP_LT : CMP_GT;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.i_cmp_valid) begin
          nan_d = nan_q | bus.i_cmp_nan;
          if (bus.i_cmp_result && !nan_d) begin
            running_d = elem_q;
            index_d   = count_q[IDX_W-1:0];
          end
          count_d = count_q + CNT_ONE;
          if (elem_last_q || (count_d == CNT_MAX)) begin
            trunc_d = !elem_last_q;
            state_d = ST_DONE;
          end else begin
            state_d = ST_ACCEPT;
          end
        end
      end
      ST_DONE: begin
        if (bus.i_out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      running_q   <= '0;
      index_q     <= '0;
      count_q     <= '0;
      mode_q      <= 1'b0;
      nan_q       <= 1'b0;
      trunc_q     <= 1'b0;
      elem_q      <= '0;
      elem_last_q <= 1'b0;
      cmp_a_q     <= '0;
      cmp_b_q     <= '0;
      cmp_op_q    <= CMP_GTE;
    end else begin
      state_q     <= state_d;
      running_q   <= running_d;
      index_q     <= index_d;
      count_q     <= count_d;
      mode_q      <= mode_d;
      nan_q       <= nan_d;
      trunc_q     <= trunc_d;
      elem_q      <= elem_d;
      elem_last_q <= elem_last_d;
      cmp_a_q     <= cmp_a_d;
      cmp_b_q     <= cmp_b_d;
      cmp_op_q    <= cmp_op_d;
    end
  end

  assign bus.o_ready     = (state_q == ST_IDLE) || (state_q == ST_ACCEPT);
  assign bus.o_cmp_valid = cmp_req;
  assign bus.o_cmp_a     = cmp_a_d;
  assign bus.o_cmp_b     = cmp_b_d;
  assign bus.o_cmp_op    = cmp_op_d;
  assign bus.o_valid     = (state_q == ST_DONE);
  assign bus.o_value     = nan_q ? QNAN : running_q;
  assign bus.o_index     = index_q;
  assign bus.o_nan_err   = nan_q;
  assign bus.o_trunc     = trunc_q;

endmodule

// File: tb/tb_fp32_maxmin_reduce.sv
// Bench for fp32_maxmin_reduce with a behavioural 1-cycle comparator and a result scoreboard.
module tb_fp32_maxmin_reduce;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fp32_maxmin_reduce_if bus_if ();

  fp32_maxmin_reduce dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    logic [31:0] value;
    logic [4:0]  index;
    logic        nan;
    logic        trunc;
  } exp_t;

  exp_t sb_q[$];

  function automatic logic is_nan32(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Map FP32 bit patterns to an unsigned total order (-0 below +0).
  function automatic logic [31:0] order_key(input logic [31:0] x);
    return x[31] ? ~x : (x | 32'h8000_0000);
  endfunction

  function automatic logic cmp_model(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    logic [31:0] ka, kb;
    ka = order_key(a);
    kb = order_key(b);
    case (op)
      3'd0:    return ka >= kb;
      3'd1:    return ka >  kb;
      3'd2:    return ka == kb;
      3'd3:    return ka <  kb;
      3'd4:    return ka <= kb;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    bus_if.i_cmp_valid  <= bus_if.o_cmp_valid;
    bus_if.i_cmp_nan    <= is_nan32(bus_if.o_cmp_a) || is_nan32(bus_if.o_cmp_b);
    bus_if.i_cmp_result <= !(is_nan32(bus_if.o_cmp_a) || is_nan32(bus_if.o_cmp_b)) &&
                           cmp_model(bus_if.o_cmp_op, bus_if.o_cmp_a, bus_if.o_cmp_b);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus_if.o_valid && bus_if.i_out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got value %h with empty scoreboard", bus_if.o_value);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result_value", bus_if.o_value, e.value);
        check("result_index", 32'(bus_if.o_index), 32'(e.index));
        check("result_nan",   32'(bus_if.o_nan_err), 32'(e.nan));
        check("result_trunc", 32'(bus_if.o_trunc), 32'(e.trunc));
      end
    end
  end

  task automatic expect_res(input logic [31:0] v, input logic [4:0] idx, input logic n,
                            input logic t);
    exp_t e;
    e.value = v; e.index = idx; e.nan = n; e.trunc = t;
    sb_q.push_back(e);
  endtask

  task automatic send(input logic [31:0] d, input logic last, input logic mode);
    int n;
    @(negedge clk);
    bus_if.i_valid = 1'b1;
    bus_if.i_data  = d;
    bus_if.i_last  = last;
    bus_if.i_mode  = mode;
    n = 0;
    while (!bus_if.o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus_if.o_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: o_ready=0 required 1 for data %h", d);
    end
    @(posedge clk);
    #1 bus_if.i_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: pending %0d required 0", sb_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.i_valid     = 1'b0;
    bus_if.i_data      = '0;
    bus_if.i_last      = 1'b0;
    bus_if.i_mode      = 1'b0;
    bus_if.i_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready",   32'(bus_if.o_ready), 32'd1);
    check("rst_valid",   32'(bus_if.o_valid), 32'd0);
    check("rst_value",   bus_if.o_value, 32'd0);
    check("rst_index",   32'(bus_if.o_index), 32'd0);
    check("rst_nan",     32'(bus_if.o_nan_err), 32'd0);
    check("rst_trunc",   32'(bus_if.o_trunc), 32'd0);
    check("rst_cmp_vld", 32'(bus_if.o_cmp_valid), 32'd0);
    check("rst_cmp_op",  32'(bus_if.o_cmp_op), 32'd0);
    rst = 1'b0;

    // max {1.0, 3.0, 2.0}
    expect_res(32'h4040_0000, 5'd1, 1'b0, 1'b0);
    send(32'h3F80_0000, 1'b0, 1'b0);
    send(32'h4040_0000, 1'b0, 1'b0);
    send(32'h4000_0000, 1'b1, 1'b0);

    // min {-2.0, 5.0, -2.0}: tie keeps index 0
    expect_res(32'hC000_0000, 5'd0, 1'b0, 1'b0);
    send(32'hC000_0000, 1'b0, 1'b1);
    send(32'h40A0_0000, 1'b0, 1'b1);
    send(32'hC000_0000, 1'b1, 1'b1);

    // single +inf: result visible right after acceptance
    expect_res(32'h7F80_0000, 5'd0, 1'b0, 1'b0);
    send(32'h7F80_0000, 1'b1, 1'b0);
    @(negedge clk);
    check("single_valid", 32'(bus_if.o_valid), 32'd1);
    check("single_value", bus_if.o_value, 32'h7F80_0000);

    // NaN at index 1
    expect_res(32'hFFFF_FFFF, 5'd0, 1'b1, 1'b0);
    send(32'h3F80_0000, 1'b0, 1'b0);
    send(32'h7FC0_0001, 1'b0, 1'b0);
    send(32'h4000_0000, 1'b1, 1'b0);

    // NaN as first element
    expect_res(32'hFFFF_FFFF, 5'd0, 1'b1, 1'b0);
    send(32'h7F80_0001, 1'b0, 1'b0);
    send(32'h3F80_0000, 1'b1, 1'b0);

    // +0 then -0 on max keeps +0; -0 then +0 takes +0
    expect_res(32'h0000_0000, 5'd0, 1'b0, 1'b0);
    send(32'h0000_0000, 1'b0, 1'b0);
    send(32'h8000_0000, 1'b1, 1'b0);
    expect_res(32'h0000_0000, 5'd1, 1'b0, 1'b0);
    send(32'h8000_0000, 1'b0, 1'b0);
    send(32'h0000_0000, 1'b1, 1'b0);

    // mode sampled only on first element (min)
    expect_res(32'h3F80_0000, 5'd1, 1'b0, 1'b0);
    send(32'h4040_0000, 1'b0, 1'b1);
    send(32'h3F80_0000, 1'b0, 1'b0);
    send(32'h4000_0000, 1'b1, 1'b0);

    // 32 elements without last, largest at 20; 33rd starts a new vector
    expect_res(32'h4100_0000, 5'd20, 1'b0, 1'b1);
    for (int k = 0; k < 32; k++) begin
      send((k == 20) ? 32'h4100_0000 : (32'h4000_0000 + 32'(k)), 1'b0, 1'b0);
    end
    expect_res(32'hBF80_0000, 5'd0, 1'b0, 1'b0);
    send(32'hBF80_0000, 1'b1, 1'b0);
    drain();

    // downstream stall for 5 cycles
    bus_if.i_out_ready = 1'b0;
    expect_res(32'h4228_0000, 5'd0, 1'b0, 1'b0);
    send(32'h4228_0000, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hold_valid", 32'(bus_if.o_valid), 32'd1);
      check("hold_value", bus_if.o_value, 32'h4228_0000);
      check("hold_ready", 32'(bus_if.o_ready), 32'd0);
    end
    @(posedge clk);
    #1 bus_if.i_out_ready = 1'b1;
    drain();

    // reset while waiting for the comparator
    send(32'h3F80_0000, 1'b0, 1'b0);
    send(32'h4000_0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("wrst_valid", 32'(bus_if.o_valid), 32'd0);
    check("wrst_ready", 32'(bus_if.o_ready), 32'd1);
    check("wrst_value", bus_if.o_value, 32'd0);
    rst = 1'b0;
    expect_res(32'h40A0_0000, 5'd0, 1'b0, 1'b0);
    send(32'h40A0_0000, 1'b0, 1'b0);
    send(32'hBF80_0000, 1'b1, 1'b0);
    drain();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
